// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline: load-use
// stalls, branch flushes, operand forwarding and data-memory wait handling.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_dec_i,
  input  logic [4:0]       rs2_dec_i,
  input  logic             rs1_used_dec_i,
  input  logic             rs2_used_dec_i,
  input  logic             valid_ex_i,
  input  logic             rf_en_ex_i,
  input  logic             is_lw_ex_i,
  input  logic [4:0]       rd_ex_i,
  input  logic             branch_taken_ex_i,
  input  logic             valid_mem_i,
  input  logic             rf_en_mem_i,
  input  logic             is_lw_mem_i,
  input  logic             mem_wr_mem_i,
  input  logic [4:0]       rd_mem_i,
  input  logic             valid_wb_i,
  input  logic             rf_en_wb_i,
  input  logic [4:0]       rd_wb_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             hold_fetch_o,
  output logic             hold_dec_o,
  output logic             hold_ex_o,
  output logic             hold_mem_o,
  output logic             clr_dec_o,
  output logic             clr_ex_o,
  output logic             clr_wb_o,
  output logic [1:0]       fwd_sel_p1_o,
  output logic [1:0]       fwd_sel_p2_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // state_q is the FSM state, kept as a named signal for checker binding.
  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              bus_err_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic mem_op, mem_stall, err_set, load_use, branch_flush;

  assign mem_op = valid_mem_i & (is_lw_mem_i | mem_wr_mem_i);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && !dmem_ack_i) begin
          state_d    = S_WAIT;
          wait_cnt_d = WCNT_W'(1);
          mem_stall  = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_ack_i) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_MAX) begin
          // Abandon the access; the pipeline is released this cycle.
          state_d    = S_IDLE;
          wait_cnt_d = '0;
          err_set    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          mem_stall  = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (err_set) bus_err_q <= 1'b1;
    end
  end

  assign load_use = valid_ex_i & is_lw_ex_i & rf_en_ex_i & (rd_ex_i != 5'd0) &
                    ((rs1_used_dec_i & (rs1_dec_i == rd_ex_i)) |
                     (rs2_used_dec_i & (rs2_dec_i == rd_ex_i)));
  assign branch_flush = branch_taken_ex_i & valid_ex_i;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'd0;
    if (valid_mem_i && rf_en_mem_i && !is_lw_mem_i && rd_mem_i != 5'd0 && rd_mem_i == rs)
      sel = 2'd1;
    else if (valid_wb_i && rf_en_wb_i && rd_wb_i != 5'd0 && rd_wb_i == rs)
      sel = 2'd2;
    return sel;
  endfunction

  // A memory stall freezes everything up to MEM; flush and bubble wait for release.
  always_comb begin
    dmem_req_o   = 1'b0;
    hold_fetch_o = 1'b0;
    hold_dec_o   = 1'b0;
    hold_ex_o    = 1'b0;
    hold_mem_o   = 1'b0;
    clr_dec_o    = 1'b0;
    clr_ex_o     = 1'b0;
    clr_wb_o     = 1'b0;
    fwd_sel_p1_o = 2'd0;
    fwd_sel_p2_o = 2'd0;
    if (reset) begin
      dmem_req_o   = mem_op;
      fwd_sel_p1_o = fwd_sel(rs1_dec_i);
      fwd_sel_p2_o = fwd_sel(rs2_dec_i);
      if (mem_stall) begin
        hold_fetch_o = 1'b1;
        hold_dec_o   = 1'b1;
        hold_ex_o    = 1'b1;
        hold_mem_o   = 1'b1;
        clr_wb_o     = 1'b1;
      end else if (branch_flush) begin
        clr_dec_o = 1'b1;
        clr_ex_o  = 1'b1;
      end else if (load_use) begin
        hold_fetch_o = 1'b1;
        hold_dec_o   = 1'b1;
        clr_ex_o     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt_q <= '0;
    else if (hold_fetch_o && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign bus_err_o   = bus_err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level
// reference model derived from the controller's rules.
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT_P = 4;
  localparam int CNT_W_P   = 32;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_dec, rs2_dec, rd_ex, rd_mem, rd_wb;
  logic rs1_used, rs2_used, valid_ex, rf_en_ex, is_lw_ex, branch_taken;
  logic valid_mem, rf_en_mem, is_lw_mem, mem_wr_mem, valid_wb, rf_en_wb, dmem_ack;
  logic dmem_req, hold_fetch, hold_dec, hold_ex, hold_mem, clr_dec, clr_ex, clr_wb;
  logic [1:0] fwd_p1, fwd_p2;
  logic bus_err;
  logic [CNT_W_P-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT_P), .CNT_W(CNT_W_P)) dut (
    .clk(clk), .reset(reset),
    .rs1_dec_i(rs1_dec), .rs2_dec_i(rs2_dec),
    .rs1_used_dec_i(rs1_used), .rs2_used_dec_i(rs2_used),
    .valid_ex_i(valid_ex), .rf_en_ex_i(rf_en_ex), .is_lw_ex_i(is_lw_ex), .rd_ex_i(rd_ex),
    .branch_taken_ex_i(branch_taken),
    .valid_mem_i(valid_mem), .rf_en_mem_i(rf_en_mem), .is_lw_mem_i(is_lw_mem),
    .mem_wr_mem_i(mem_wr_mem), .rd_mem_i(rd_mem),
    .valid_wb_i(valid_wb), .rf_en_wb_i(rf_en_wb), .rd_wb_i(rd_wb),
    .dmem_ack_i(dmem_ack), .dmem_req_o(dmem_req),
    .hold_fetch_o(hold_fetch), .hold_dec_o(hold_dec), .hold_ex_o(hold_ex),
    .hold_mem_o(hold_mem), .clr_dec_o(clr_dec), .clr_ex_o(clr_ex), .clr_wb_o(clr_wb),
    .fwd_sel_p1_o(fwd_p1), .fwd_sel_p2_o(fwd_p2),
    .bus_err_o(bus_err), .stall_cnt_o(stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: expected stall counter after each clock edge.
  logic [CNT_W_P-1:0] exp_q[$];

  // Reference model state: cycles the current access has been pending (0 = none).
  int                 m_waited;
  bit                 m_err;
  logic [CNT_W_P-1:0] m_cnt;
  bit                 e_stall, e_hf, e_mem_op;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (valid_mem && rf_en_mem && !is_lw_mem && rd_mem != 0 && rd_mem == rs) return 2'd1;
    if (valid_wb && rf_en_wb && rd_wb != 0 && rd_wb == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic clear_inputs();
    {rs1_dec, rs2_dec, rd_ex, rd_mem, rd_wb} = '0;
    {rs1_used, rs2_used, valid_ex, rf_en_ex, is_lw_ex, branch_taken} = '0;
    {valid_mem, rf_en_mem, is_lw_mem, mem_wr_mem, valid_wb, rf_en_wb, dmem_ack} = '0;
  endtask

  // Compare all outputs against the model for the inputs currently applied.
  task automatic eval();
    bit lu, br, r, e_cd, e_ce;
    #1;
    r        = reset;
    e_mem_op = valid_mem && (is_lw_mem || mem_wr_mem);
    lu = valid_ex && is_lw_ex && rf_en_ex && rd_ex != 0 &&
         ((rs1_used && rs1_dec == rd_ex) || (rs2_used && rs2_dec == rd_ex));
    br = branch_taken && valid_ex;
    if (m_waited == 0) e_stall = e_mem_op && !dmem_ack;
    else               e_stall = !dmem_ack && (m_waited < TIMEOUT_P);
    e_hf = r && (e_stall || (!br && lu));
    e_cd = r && !e_stall && br;
    e_ce = r && !e_stall && (br || lu);
    check("dmem_req",   32'(dmem_req),   32'(r && e_mem_op));
    check("hold_fetch", 32'(hold_fetch), 32'(e_hf));
    check("hold_dec",   32'(hold_dec),   32'(e_hf));
    check("hold_ex",    32'(hold_ex),    32'(r && e_stall));
    check("hold_mem",   32'(hold_mem),   32'(r && e_stall));
    check("clr_wb",     32'(clr_wb),     32'(r && e_stall));
    check("clr_dec",    32'(clr_dec),    32'(e_cd));
    check("clr_ex",     32'(clr_ex),     32'(e_ce));
    check("fwd_p1",     32'(fwd_p1),     r ? 32'(ref_fwd(rs1_dec)) : 32'd0);
    check("fwd_p2",     32'(fwd_p2),     r ? 32'(ref_fwd(rs2_dec)) : 32'd0);
    check("bus_err",    32'(bus_err),    32'(m_err));
    if (exp_q.size() > 0) check("stall_cnt", stall_cnt, exp_q.pop_front());
  endtask

  // Clock edge: advance the model, then return at the following negedge.
  task automatic advance();
    @(posedge clk);
    if (!reset) begin
      m_waited = 0;
      m_err    = 0;
      m_cnt    = '0;
    end else begin
      if (e_hf && m_cnt != '1) m_cnt = m_cnt + 1;
      if (m_waited == 0) begin
        if (e_mem_op && !dmem_ack) m_waited = 1;
      end else if (dmem_ack) m_waited = 0;
      else if (m_waited == TIMEOUT_P) begin
        m_waited = 0;
        m_err    = 1;
      end else m_waited++;
    end
    exp_q.push_back(m_cnt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    eval();
    advance();
    reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset    = 1'b0;
    m_waited = 0;
    m_err    = 0;
    m_cnt    = '0;
    repeat (2) @(negedge clk);
    eval();
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    advance();
    reset = 1'b1;

    // Load-use on rs1 followed by forwarding from writeback.
    valid_ex = 1; is_lw_ex = 1; rf_en_ex = 1; rd_ex = 5'd5;
    rs1_dec = 5'd5; rs1_used = 1;
    eval();
    check("lu_hold_fetch", 32'(hold_fetch), 32'd1);
    check("lu_clr_ex", 32'(clr_ex), 32'd1);
    advance();
    clear_inputs();
    rs1_dec = 5'd5; rs1_used = 1; valid_wb = 1; rf_en_wb = 1; rd_wb = 5'd5;
    eval();
    check("lu_fwd_p1", 32'(fwd_p1), 32'd2);
    check("lu_stall_cnt", stall_cnt, 32'd1);
    advance();

    // Load to x0 never stalls.
    clear_inputs();
    valid_ex = 1; is_lw_ex = 1; rf_en_ex = 1; rd_ex = 5'd0; rs1_used = 1;
    eval();
    check("x0_hold_fetch", 32'(hold_fetch), 32'd0);
    check("x0_fwd_p1", 32'(fwd_p1), 32'd0);
    advance();

    // Branch beats load-use.
    clear_inputs();
    valid_ex = 1; is_lw_ex = 1; rf_en_ex = 1; rd_ex = 5'd3; rs2_dec = 5'd3; rs2_used = 1;
    branch_taken = 1;
    eval();
    check("br_clr_dec", 32'(clr_dec), 32'd1);
    check("br_hold_fetch", 32'(hold_fetch), 32'd0);
    advance();
    clear_inputs();
    eval();
    check("br_stall_cnt", stall_cnt, 32'd1);
    advance();

    // Store acknowledged on the fourth cycle: three stall cycles.
    do_reset();
    valid_mem = 1; mem_wr_mem = 1;
    for (int i = 0; i < 3; i++) begin
      eval();
      check("st_hold_mem", 32'(hold_mem), 32'd1);
      advance();
    end
    dmem_ack = 1;
    eval();
    check("st_ack_hold", 32'(hold_fetch), 32'd0);
    advance();
    eval();
    check("st_stall_cnt", stall_cnt, 32'd3);
    check("zw_hold", 32'(hold_fetch), 32'd0);
    advance();

    // Timeout: four stall cycles, then release with sticky error.
    dmem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      eval();
      check("to_clr_wb", 32'(clr_wb), 32'd1);
      advance();
    end
    eval();
    check("to_release", 32'(hold_fetch), 32'd0);
    advance();
    clear_inputs();
    eval();
    check("to_bus_err", 32'(bus_err), 32'd1);
    advance();
    valid_mem = 1; is_lw_mem = 1; dmem_ack = 1;
    eval();
    advance();
    clear_inputs();
    eval();
    check("to_err_sticky", 32'(bus_err), 32'd1);
    advance();

    // Forwarding priority on rs2, then reset in the middle of a wait.
    valid_mem = 1; rf_en_mem = 1; rd_mem = 5'd7; valid_wb = 1; rf_en_wb = 1; rd_wb = 5'd7;
    rs2_dec = 5'd7;
    eval();
    check("fw_mem", 32'(fwd_p2), 32'd1);
    advance();
    is_lw_mem = 1; dmem_ack = 1;
    eval();
    check("fw_wb", 32'(fwd_p2), 32'd2);
    advance();
    dmem_ack = 0;
    repeat (2) begin
      eval();
      advance();
    end
    reset = 1'b0;
    eval();
    check("rw_hold", 32'(hold_fetch), 32'd0);
    advance();
    reset = 1'b1;
    eval();
    check("rw_bus_err", 32'(bus_err), 32'd0);
    check("rw_restall", 32'(hold_fetch), 32'd1);
    advance();
    for (int i = 0; i < 4; i++) begin
      eval();
      advance();
    end

    // Randomized traffic over a small register range to provoke matches.
    for (int c = 0; c < 800; c++) begin
      reset        = ($urandom_range(0, 59) != 0);
      rs1_dec      = 5'($urandom_range(0, 3));
      rs2_dec      = 5'($urandom_range(0, 3));
      rs1_used     = 1'($urandom_range(0, 1));
      rs2_used     = 1'($urandom_range(0, 1));
      valid_ex     = ($urandom_range(0, 3) != 0);
      rf_en_ex     = ($urandom_range(0, 3) != 0);
      is_lw_ex     = 1'($urandom_range(0, 1));
      rd_ex        = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 5) == 0);
      valid_mem    = 1'($urandom_range(0, 1));
      rf_en_mem    = 1'($urandom_range(0, 1));
      is_lw_mem    = ($urandom_range(0, 3) == 0);
      mem_wr_mem   = ($urandom_range(0, 3) == 0);
      rd_mem       = 5'($urandom_range(0, 3));
      valid_wb     = 1'($urandom_range(0, 1));
      rf_en_wb     = 1'($urandom_range(0, 1));
      rd_wb        = 5'($urandom_range(0, 3));
      dmem_ack     = ($urandom_range(0, 3) == 0);
      eval();
      advance();
    end
    reset = 1'b1;
    clear_inputs();
    eval();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
